// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle shift unit for the area-reduced core. Performs SLL / SRL / SRA by
// moving the operand at most STEP bit positions per clock, so only a small
// shifter is needed instead of a full 32-bit barrel shifter.
//
// Handshake: start_i is accepted in IDLE or DONE. busy_o is high while the
// operation is in progress, done_o pulses for one cycle when it completes and
// c_o is updated only on completion. abort_i cancels an in-flight shift.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   start_i  : request a new shift (IDLE or DONE only)
//   abort_i  : cancel the shift in progress
//   a_i      : 32-bit operand       (sampled on the accept edge)
//   shamt_i  : 5-bit shift amount   (sampled on the accept edge)
//   type_i   : 4-bit ALU shift code (sampled on the accept edge)
//   busy_o   : shift in progress
//   done_o   : one-cycle completion pulse
//   c_o      : result register
// -----------------------------------------------------------------------------
module iterative_shifter #(
   parameter int STEP = 1          // legal: 1, 2, 4, 8, 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [31:0] a_i,
   input  logic [4:0]  shamt_i,
   input  logic [3:0]  type_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] c_o
);

   // ALU operation codes shared with the rest of the core (defines.v).
   localparam logic [3:0] ALU_SLL = 4'b0001;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SRA = 4'b1101;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [4:0] STEP_AMT = 5'(STEP);

   logic [1:0]  state_q, state_d;
   logic [31:0] work_q,  work_d;
   logic [4:0]  rem_q,   rem_d;
   logic [3:0]  type_q,  type_d;
   logic        sign_q,  sign_d;
   logic [31:0] c_q,     c_d;

   logic [4:0]  step_k;
   logic [31:0] sign_fill;
   logic [31:0] shifted;
   logic        type_ok;

   always_comb begin
      // The final step may be shorter than STEP; k never exceeds rem so rem
      // cannot wrap.
      step_k    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
      // SRA fills with the sign captured at accept rather than work_q[31],
      // which keeps the fill correct regardless of intermediate contents.
      sign_fill = sign_q ? ~(32'hFFFF_FFFF >> step_k) : 32'h0;

      case (type_q)
         ALU_SLL: shifted = work_q << step_k;
         ALU_SRL: shifted = work_q >> step_k;
         ALU_SRA: shifted = (work_q >> step_k) | sign_fill;
         default: shifted = work_q;
      endcase

      type_ok = (type_i == ALU_SLL) || (type_i == ALU_SRL) || (type_i == ALU_SRA);
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      type_d  = type_q;
      sign_d  = sign_q;
      c_d     = c_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               work_d = a_i;
               rem_d  = shamt_i;
               type_d = type_i;
               sign_d = a_i[31];
               if (!type_ok) begin
                  c_d     = 32'h0;
                  state_d = S_DONE;
               end else if (shamt_i == 5'd0) begin
                  c_d     = a_i;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_SHIFT: begin
            // abort wins over a completion in the same cycle; start_i is
            // deliberately ignored here.
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               work_d = shifted;
               rem_d  = rem_q - step_k;
               if (rem_q == step_k) begin
                  c_d     = shifted;
                  state_d = S_DONE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         work_q  <= 32'h0;
         rem_q   <= 5'd0;
         type_q  <= 4'd0;
         sign_q  <= 1'b0;
         c_q     <= 32'h0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         type_q  <= type_d;
         sign_q  <= sign_d;
         c_q     <= c_d;
      end
   end

   assign busy_o = (state_q == S_SHIFT);
   assign done_o = (state_q == S_DONE);
   assign c_o    = c_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// -----------------------------------------------------------------------------
// Testbench for iterative_shifter. Two instances (STEP=1 and STEP=4) share the
// same stimulus; each is checked cycle by cycle against a reference model that
// computes the result with plain shift operators and the latency from
// 1 + ceil(shamt/STEP).
// -----------------------------------------------------------------------------
module tb_iterative_shifter;

   localparam logic [3:0] SLL = 4'b0001;
   localparam logic [3:0] SRL = 4'b0101;
   localparam logic [3:0] SRA = 4'b1101;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] a;
   logic [4:0]  sh;
   logic [3:0]  ty;

   logic        busy_w [2];
   logic        done_w [2];
   logic [31:0] c_w    [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] prev [2];
   int          steps [2] = '{1, 4};

   always #5 clk = ~clk;

   iterative_shifter #(.STEP(1)) u_s1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .a_i(a), .shamt_i(sh), .type_i(ty),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .c_o(c_w[0])
   );

   iterative_shifter #(.STEP(4)) u_s4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .a_i(a), .shamt_i(sh), .type_i(ty),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .c_o(c_w[1])
   );

   function automatic logic supported(input logic [3:0] t);
      return (t == SLL) || (t == SRL) || (t == SRA);
   endfunction

   function automatic logic [31:0] ref_result(input logic [31:0] x, input logic [4:0] s,
                                              input logic [3:0] t);
      case (t)
         SLL:     return x << s;
         SRL:     return x >> s;
         SRA:     return 32'($signed(x) >>> s);
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [4:0] s, input logic [3:0] t, input int step);
      if (!supported(t) || s == 5'd0) return 1;
      return 1 + (int'(s) + step - 1) / step;
   endfunction

   // Runs one operation on both instances and checks busy/done/c every cycle.
   // abort_at / pulse_at: after the sample at edge n, raise abort_i / start_i
   // for one cycle (0 = never).
   task automatic run_op(input string name, input logic [31:0] oa, input logic [4:0] osh,
                         input logic [3:0] oty, input int abort_at, input int pulse_at);
      int          lat [2];
      logic        abt [2];
      logic [31:0] res;
      int          nmax;
      logic        busy_e, done_e;
      logic [31:0] c_e;
      res = ref_result(oa, osh, oty);
      for (int i = 0; i < 2; i++) begin
         lat[i] = ref_lat(osh, oty, steps[i]);
         abt[i] = (abort_at > 0) && (abort_at < lat[i]);
      end
      nmax = ((lat[0] > lat[1]) ? lat[0] : lat[1]) + 1;

      a = oa; sh = osh; ty = oty; start = 1'b1;
      abort = 1'($urandom_range(0, 1));   // abort at accept time must be ignored
      for (int n = 1; n <= nmax; n++) begin
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0;
         a = $urandom; sh = 5'($urandom); ty = 4'($urandom);
         for (int i = 0; i < 2; i++) begin
            done_e = (n == lat[i]) && !abt[i];
            busy_e = (n < lat[i]) && !(abt[i] && n > abort_at);
            c_e    = (n >= lat[i] && !abt[i]) ? res : prev[i];
            n_cmp++;
            if (busy_w[i] !== busy_e) begin
               n_bad++;
               $display("FAIL %s busy step=%0d edge=%0d got=%b want=%b", name, steps[i], n, busy_w[i], busy_e);
            end
            n_cmp++;
            if (done_w[i] !== done_e) begin
               n_bad++;
               $display("FAIL %s done step=%0d edge=%0d got=%b want=%b", name, steps[i], n, done_w[i], done_e);
            end
            n_cmp++;
            if (c_w[i] !== c_e) begin
               n_bad++;
               $display("FAIL %s c_o step=%0d edge=%0d got=%h want=%h", name, steps[i], n, c_w[i], c_e);
            end
         end
         if (n == pulse_at) begin
            start = 1'b1; a = $urandom; sh = 5'($urandom); ty = SLL;
         end
         if (n == abort_at) abort = 1'b1;
      end
      abort = 1'b0;
      for (int i = 0; i < 2; i++) if (!abt[i]) prev[i] = res;
      $display("op %-10s a=%h sh=%0d ty=%h exp=%h lat1=%0d lat4=%0d abort@%0d pulse@%0d",
               name, oa, osh, oty, res, lat[0], lat[1], abort_at, pulse_at);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; sh = '0; ty = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || c_w[i] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset step=%0d got busy=%b done=%b c=%h want 0/0/0",
                     steps[i], busy_w[i], done_w[i], c_w[i]);
         end
         prev[i] = 32'h0;
      end
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_plan_vectors();
      run_op("sll31", 32'h0000_0001, 5'd31, SLL, 0, 0);
      run_op("sra4",  32'h8000_0000, 5'd4,  SRA, 0, 0);
      run_op("srl4",  32'h8000_0000, 5'd4,  SRL, 0, 0);
      run_op("zero",  32'hDEAD_BEEF, 5'd0,  SRL, 0, 0);
      run_op("badty", 32'h1234_5678, 5'd5,  4'b0000, 0, 0);
      run_op("srl7",  32'hFFFF_FFFF, 5'd7,  SRL, 0, 0);
   endtask

   task automatic test_start_in_shift();
      run_op("pulse", 32'h0000_0001, 5'd20, SLL, 0, 3);
   endtask

   task automatic test_abort();
      run_op("abort",   32'h0F0F_0F0F, 5'd20, SLL, 3, 0);
      // abort on the last SHIFT cycle of the STEP=1 instance beats completion
      run_op("abortend", 32'h8765_4321, 5'd2, SRA, 2, 0);
   endtask

   task automatic test_back_to_back();
      a = 32'h10; sh = 5'd1; ty = SRL; start = 1'b1; abort = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy_w[i] !== 1'b1 || done_w[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first_busy step=%0d got busy=%b done=%b want 1/0", steps[i], busy_w[i], done_w[i]);
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (done_w[i] !== 1'b1 || c_w[i] !== 32'h8) begin
            n_bad++;
            $display("FAIL b2b_first_done step=%0d got done=%b c=%h want 1/00000008", steps[i], done_w[i], c_w[i]);
         end
      end
      a = 32'h3; sh = 5'd1; ty = SLL; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy_w[i] !== 1'b1 || done_w[i] !== 1'b0 || c_w[i] !== 32'h8) begin
            n_bad++;
            $display("FAIL b2b_accept step=%0d got busy=%b done=%b c=%h want 1/0/00000008",
                     steps[i], busy_w[i], done_w[i], c_w[i]);
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (done_w[i] !== 1'b1 || c_w[i] !== 32'h6) begin
            n_bad++;
            $display("FAIL b2b_second_done step=%0d got done=%b c=%h want 1/00000006", steps[i], done_w[i], c_w[i]);
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle step=%0d got busy=%b done=%b want 0/0", steps[i], busy_w[i], done_w[i]);
         end
         prev[i] = 32'h6;
      end
      $display("op b2b        srl 0x10>>1 then sll 3<<1 exp=00000008,00000006");
   endtask

   task automatic test_reset_mid_shift();
      a = 32'h1; sh = 5'd20; ty = SLL; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy_w[0] !== 1'b1 || busy_w[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_busy got busy1=%b busy4=%b want 1/1", busy_w[0], busy_w[1]);
      end
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || c_w[i] !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid step=%0d got busy=%b done=%b c=%h want 0/0/0",
                     steps[i], busy_w[i], done_w[i], c_w[i]);
         end
         prev[i] = 32'h0;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || c_w[i] !== 32'h0) begin
               n_bad++;
               $display("FAIL rst_after step=%0d cycle=%0d got busy=%b done=%b c=%h want 0/0/0",
                        steps[i], n, busy_w[i], done_w[i], c_w[i]);
            end
         end
      end
      $display("op rst_mid    reset during SHIFT, no done afterwards");
   endtask

   task automatic test_random();
      logic [31:0] ra;
      logic [4:0]  rsh;
      logic [3:0]  rty;
      int          ab, pu, minlat;
      for (int t = 0; t < 30; t++) begin
         ra = $urandom;
         case ($urandom_range(0, 9))
            0:       rty = 4'b0000;
            1, 2, 3: rty = SLL;
            4, 5, 6: rty = SRL;
            default: rty = SRA;
         endcase
         if (supported(rty)) rsh = 5'($urandom_range(0, 31));
         else                rsh = 5'($urandom_range(1, 31));
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
         minlat = ref_lat(rsh, rty, 4);
         pu = 0;
         if (minlat > 1 && $urandom_range(0, 1) == 1) begin
            pu = $urandom_range(1, minlat - 1);
            if (ab != 0 && pu >= ab) pu = 0;
         end
         run_op("random", ra, rsh, rty, ab, pu);
      end
   endtask

   initial begin
      test_reset();
      test_plan_vectors();
      test_start_in_shift();
      test_abort();
      test_back_to_back();
      test_reset_mid_shift();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
